// File: rtl/periph_arbiter.sv
// periph_arbiter: round-robin arbiter funnelling NUM_PERIPHS word sources into one registered word
// for the ft601_controller. Define PERIPH_ARB_BURST_EN to hold a grant for up to MAX_BURST words.
module periph_arbiter #(
  parameter int unsigned NUM_PERIPHS = 4,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic [NUM_PERIPHS-1:0]           req_valid,
  input  logic [NUM_PERIPHS*32-1:0]        req_data,
  input  logic [NUM_PERIPHS*4-1:0]         req_be,
  output logic [NUM_PERIPHS-1:0]           req_ready,
  output logic [31:0]                      data_i,
  output logic [3:0]                       i_valid,
  output logic                             periph_data_available,
  input  logic                             read_periph_data,
  output logic [$clog2(NUM_PERIPHS)-1:0]   grant_id
);

  localparam int unsigned IdW  = $clog2(NUM_PERIPHS);
  localparam int unsigned CntW = 8;
`ifdef PERIPH_ARB_BURST_EN
  localparam int unsigned BurstLim = MAX_BURST;
`else
  // Without bursts every grant ends after a single word; MAX_BURST has no effect.
  localparam int unsigned BurstLim = 1 + 0 * MAX_BURST;
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   burst_q, burst_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              avail_q, avail_d;

  logic              found;
  logic [IdW-1:0]    pick;
  logic [IdW-1:0]    cand;
  logic              load;
  logic [CntW-1:0]   burst_inc;

  // First requester searching upward from rr_ptr+1, wrapping modulo NUM_PERIPHS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_PERIPHS; i++) begin
      cand = IdW'((32'(rr_ptr_q) + i) % NUM_PERIPHS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A word is popped when the output register is free (empty or being read this edge).
  always_comb begin
    load      = (state_q == GRANT) && (!avail_q || read_periph_data) && req_valid[grant_q];
    burst_inc = burst_q + CntW'(1);
    req_ready = '0;
    req_ready[grant_q] = load;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    data_d   = data_q;
    be_d     = be_q;
    avail_d  = avail_q && !read_periph_data;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          rr_ptr_d = pick;
          burst_d  = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!req_valid[grant_q]) begin
          state_d = IDLE;
        end else if (load) begin
          data_d  = req_data[32'(grant_q)*32 +: 32];
          be_d    = req_be[32'(grant_q)*4 +: 4];
          avail_d = 1'b1;
          burst_d = burst_inc;
          if (burst_inc == CntW'(BurstLim)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IdW'(NUM_PERIPHS - 1);
      burst_q  <= '0;
      data_q   <= '0;
      be_q     <= '0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      data_q   <= data_d;
      be_q     <= be_d;
      avail_q  <= avail_d;
    end
  end

  assign data_i                = data_q;
  assign i_valid               = be_q;
  assign periph_data_available = avail_q;
  assign grant_id              = grant_q;

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 SHALL have parameter NUM_PERIPHS, default 4, number of requesting peripherals (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum words per grant (1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_l  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  NUM_PERIPHS  bit p high: peripheral p presents a word.
REQ-006 SHALL have port req_data  in  NUM_PERIPHS*32  word of peripheral p in bits [32p+31:32p].
REQ-007 SHALL have port req_be  in  NUM_PERIPHS*4  byte-valid of peripheral p in bits [4p+3:4p].
REQ-008 SHALL have port req_ready  out  NUM_PERIPHS  one-cycle pop pulse: word of peripheral p taken this edge.
REQ-009 SHALL have port data_i  out  32  registered word to ft601_controller.
REQ-010 SHALL have port i_valid  out  4  registered byte-valid to ft601_controller.
REQ-011 SHALL have port periph_data_available  out  1  data_i/i_valid hold a valid word.
REQ-012 SHALL have port read_periph_data  in  1  controller consumes the held word at this edge.
REQ-013 SHALL have port grant_id  out  clog2(NUM_PERIPHS)  currently/last granted peripheral.

Function
REQ-014 FSM states IDLE and GRANT only.
REQ-015 IDLE: if any req_valid bit set, pick first set bit searching upward from rr_ptr+1 modulo NUM_PERIPHS, register it into grant_id, go to GRANT, clear burst count.
REQ-016 rr_ptr SHALL update to grant_id at each grant; search from NUM_PERIPHS-1 wraps to 0.
REQ-017 Output register "free" = !periph_data_available OR read_periph_data.
REQ-018 GRANT: when free and req_valid[grant_id], load req_data/req_be of grant_id into data_i/i_valid, set periph_data_available, pulse req_ready[grant_id], increment burst count.
REQ-019 At most one req_ready bit high in any cycle; never high for a non-granted peripheral.
REQ-020 GRANT exits to IDLE when req_valid[grant_id] low, or on the load that makes burst count equal MAX_BURST.
REQ-021 Read without load clears periph_data_available; simultaneous read and load keeps it high with the new word (no bubble).
REQ-022 read_periph_data while periph_data_available low SHALL be ignored.
REQ-023 Latency: req_valid high in IDLE at edge N -> grant at N, load and periph_data_available high after edge N+1.
REQ-024 data_i/i_valid SHALL stay stable while periph_data_available high and read_periph_data low.
REQ-025 req_be=4'b0000 words SHALL be transferred unchanged.

Reset
REQ-026 rst_l low SHALL immediately force: IDLE, periph_data_available=0, data_i=0, i_valid=0, req_ready=0, grant_id=0, rr_ptr=NUM_PERIPHS-1, burst count 0.
REQ-027 Reset mid-burst SHALL discard the held word; no req_ready pulse during or on the first edge after release.

Configuration
REQ-028 Macro PERIPH_ARB_BURST_EN: defined -> burst limit per REQ-020 with MAX_BURST.
REQ-029 PERIPH_ARB_BURST_EN undefined -> MAX_BURST ignored, exactly one word per grant, GRANT always returns to IDLE after its load.

Verification
REQ-030 Reset: rst_l low mid-burst, P0 valid -> all outputs 0 same cycle; after release first grant goes to P0.
REQ-031 Single requester: P2 valid with 0xFF00FF00/4'hF, read_periph_data held high -> data_i=0xFF00FF00, i_valid=4'hF two edges after request, one req_ready[2] pulse per word.
REQ-032 Round-robin: all 4 valid, burst disabled -> grant_id sequence 0,1,2,3,0.
REQ-033 Burst: burst enabled, MAX_BURST=8, P1 and P3 valid continuously, always read -> 8 words from P1 then grant_id=3.
REQ-034 Backpressure: read_periph_data low 5 cycles with word held -> data_i stable, no req_ready pulse; one read -> next word loads same edge.
REQ-035 Drop-out: P0 deasserts req_valid after 3 words -> returns to IDLE, next requester granted, no pulse to P0.
